// File: rtl/axis_window_cropper.sv
// AXI4-Stream crop stage: forwards only pixels inside a run-time window and
// regenerates tuser/tlast so the cropped frame is self-consistent downstream.
module axis_window_cropper #(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_CNT_WIDTH   = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [C_CNT_WIDTH-1:0]   win_left,
    input  logic [C_CNT_WIDTH-1:0]   win_top,
    input  logic [C_CNT_WIDTH-1:0]   win_width,
    input  logic [C_CNT_WIDTH-1:0]   win_height,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    localparam int CW = C_CNT_WIDTH;

    logic [CW-1:0]            col_q, col_d, row_q, row_d;
    logic [CW-1:0]            left_q, left_d, top_q, top_d;
    logic [CW-1:0]            width_q, width_d, height_q, height_d;
    logic                     sof_pending_q, sof_pending_d;
    logic                     m_valid_q, m_valid_d;
    logic [C_PIXEL_WIDTH-1:0] m_data_q, m_data_d;
    logic                     m_user_q, m_user_d;
    logic                     m_last_q, m_last_d;

    logic                     snext_s;
    logic                     keep_s;
    logic                     last_col_s;
    logic [CW-1:0]            cur_col_s, cur_row_s;
    logic [CW-1:0]            eff_left_s, eff_top_s, eff_width_s, eff_height_s;
    logic [CW:0]              col_off_s, row_off_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    assign s_axis_tready = ~m_valid_q | m_axis_tready;
    assign snext_s       = s_axis_tvalid & s_axis_tready;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;

    // Position and window of the beat on the input; a tuser beat restarts at
    // (0,0) and is judged against the live window inputs.
    always_comb begin
        cur_col_s    = col_q;
        cur_row_s    = row_q;
        eff_left_s   = left_q;
        eff_top_s    = top_q;
        eff_width_s  = width_q;
        eff_height_s = height_q;
        if (s_axis_tuser) begin
            cur_col_s    = {CW{1'b0}};
            cur_row_s    = {CW{1'b0}};
            eff_left_s   = win_left;
            eff_top_s    = win_top;
            eff_width_s  = win_width;
            eff_height_s = win_height;
        end else begin
            cur_col_s    = col_q;
            cur_row_s    = row_q;
        end
        // One extra bit: the MSB is the borrow, so col < left shows up as negative.
        col_off_s  = {1'b0, cur_col_s} - {1'b0, eff_left_s};
        row_off_s  = {1'b0, cur_row_s} - {1'b0, eff_top_s};
        keep_s     = ~col_off_s[CW] & (col_off_s < {1'b0, eff_width_s}) &
                     ~row_off_s[CW] & (row_off_s < {1'b0, eff_height_s});
        last_col_s = (col_off_s == ({1'b0, eff_width_s} - {{CW{1'b0}}, 1'b1}));
    end

    // Next state for counters, shadow window, sof tracking and output register.
    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        left_d        = left_q;
        top_d         = top_q;
        width_d       = width_q;
        height_d      = height_q;
        sof_pending_d = sof_pending_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_user_d      = m_user_q;
        m_last_d      = m_last_q;

        if (snext_s) begin
            if (s_axis_tlast) begin
                col_d = {CW{1'b0}};
                row_d = sat_inc(cur_row_s);
            end else begin
                col_d = sat_inc(cur_col_s);
                row_d = cur_row_s;
            end

            if (s_axis_tuser) begin
                left_d   = win_left;
                top_d    = win_top;
                width_d  = win_width;
                height_d = win_height;
            end else begin
                left_d   = left_q;
                top_d    = top_q;
                width_d  = width_q;
                height_d = height_q;
            end

            if (keep_s) begin
                m_valid_d     = 1'b1;
                m_data_d      = s_axis_tdata;
                m_last_d      = last_col_s | s_axis_tlast;
                m_user_d      = sof_pending_q | s_axis_tuser;
                sof_pending_d = 1'b0;
            end else begin
                // A dropped beat still frees the output register if it drained.
                if (m_axis_tready) begin
                    m_valid_d = 1'b0;
                end else begin
                    m_valid_d = m_valid_q;
                end
                if (s_axis_tuser) begin
                    sof_pending_d = 1'b1;
                end else begin
                    sof_pending_d = sof_pending_q;
                end
            end
        end else begin
            if (m_axis_tready) begin
                m_valid_d = 1'b0;
            end else begin
                m_valid_d = m_valid_q;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q         <= {CW{1'b0}};
            row_q         <= {CW{1'b0}};
            left_q        <= {CW{1'b0}};
            top_q         <= {CW{1'b0}};
            width_q       <= {CW{1'b0}};
            height_q      <= {CW{1'b0}};
            sof_pending_q <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= {C_PIXEL_WIDTH{1'b0}};
            m_user_q      <= 1'b0;
            m_last_q      <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            left_q        <= left_d;
            top_q         <= top_d;
            width_q       <= width_d;
            height_q      <= height_d;
            sof_pending_q <= sof_pending_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_user_q      <= m_user_d;
            m_last_q      <= m_last_d;
        end
    end

endmodule
